// File: rtl/matching_memory_pkg.sv
// Shared definitions for the matching memory: destination-option encodings,
// packet width helpers and the controller state type.
package matching_memory_pkg;

  localparam int DEST_OPTION_W = 3;

  localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_EXEC  = 3'd0;
  localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_LEFT  = 3'd1;
  localparam logic [DEST_OPTION_W-1:0] DEST_OPTION_RIGHT = 3'd2;

  localparam int ADDR_WIDTH_DEF  = 16;
  localparam int COLOR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int IDX_WIDTH_DEF   = 6;

  // {dest_option, dest_addr, color, data}
  function automatic int worker_result_width(input int addr_w, input int color_w,
                                             input int data_w);
    return DEST_OPTION_W + addr_w + color_w + data_w;
  endfunction

  // {dest_option, dest_addr, color, data1, data2}
  function automatic int packet_request_width(input int addr_w, input int color_w,
                                              input int data_w);
    return DEST_OPTION_W + addr_w + color_w + 2 * data_w;
  endfunction

  typedef enum logic [1:0] {
    S_READ     = 2'd0,
    S_LOOKUP   = 2'd1,
    S_PR_WRITE = 2'd2
  } mm_state_e;

endpackage

// File: rtl/matching_memory_if.sv
// Worker-result input channel and packet-request output channel of the
// matching memory, bundled with the dispatcher-facing (master) and
// matching-memory-facing (slave) views.
interface matching_memory_if
  import matching_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) ();

  localparam int WR_W = worker_result_width(ADDR_WIDTH, COLOR_WIDTH, DATA_WIDTH);
  localparam int PR_W = packet_request_width(ADDR_WIDTH, COLOR_WIDTH, DATA_WIDTH);

  logic            RECEIVE_WR_VALID;
  logic [WR_W-1:0] RECEIVE_WR_DATA;
  logic            RECEIVE_WR_READY;
  logic            SEND_PR_VALID;
  logic [PR_W-1:0] SEND_PR_DATA;
  logic            SEND_PR_READY;

  modport master (
    output RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_PR_READY,
    input  RECEIVE_WR_READY, SEND_PR_VALID, SEND_PR_DATA
  );

  modport slave (
    input  RECEIVE_WR_VALID, RECEIVE_WR_DATA, SEND_PR_READY,
    output RECEIVE_WR_READY, SEND_PR_VALID, SEND_PR_DATA
  );

endinterface

// File: rtl/matching_memory_match_table.sv
// Operand store for waiting tokens: one write port, one synchronous read port.
// Contents are not reset; entry validity lives in the controller.
module match_table #(
  parameter int IDX_WIDTH   = 6,
  parameter int ENTRY_WIDTH = 65
) (
  input  logic                   CLK,
  input  logic                   wr_en_i,
  input  logic [IDX_WIDTH-1:0]   wr_addr_i,
  input  logic [ENTRY_WIDTH-1:0] wr_data_i,
  input  logic                   rd_en_i,
  input  logic [IDX_WIDTH-1:0]   rd_addr_i,
  output logic [ENTRY_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
  logic [ENTRY_WIDTH-1:0] rd_q;

  // Store a token's side, tag and operand.
  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Registered read, launched when a token is accepted.
  always_ff @(posedge CLK) begin
    if (rd_en_i) rd_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/matching_memory.sv
// Matching memory: pairs LEFT and RIGHT operand tokens that share a
// (dest_addr, color) tag and emits one execute packet per pair.
// One token is in flight at a time; conflicts raise a sticky MATCH_ERROR.
module matching_memory
  import matching_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int COLOR_WIDTH = COLOR_WIDTH_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  matching_memory_if.slave     bus,
  output logic                 MATCH_ERROR,
  output logic [IDX_WIDTH:0]   OCCUPANCY
);

  localparam int DEPTH   = 1 << IDX_WIDTH;
  localparam int WR_W    = worker_result_width(ADDR_WIDTH, COLOR_WIDTH, DATA_WIDTH);
  localparam int PR_W    = packet_request_width(ADDR_WIDTH, COLOR_WIDTH, DATA_WIDTH);
  localparam int TAG_W   = ADDR_WIDTH + COLOR_WIDTH;
  localparam int ENTRY_W = 1 + TAG_W + DATA_WIDTH;

  // Field access on a worker-result word.
  function automatic logic [DEST_OPTION_W-1:0] wr_opt(input logic [WR_W-1:0] t);
    return t[WR_W-1 -: DEST_OPTION_W];
  endfunction

  function automatic logic [TAG_W-1:0] wr_tag(input logic [WR_W-1:0] t);
    return t[DATA_WIDTH +: TAG_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_data(input logic [WR_W-1:0] t);
    return t[DATA_WIDTH-1:0];
  endfunction

  // Hash the tag into a table slot; color is resized to the address width first.
  function automatic logic [IDX_WIDTH-1:0] wr_index(input logic [WR_W-1:0] t);
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] color_rs;
    addr     = t[DATA_WIDTH+COLOR_WIDTH +: ADDR_WIDTH];
    color_rs = ADDR_WIDTH'(t[DATA_WIDTH +: COLOR_WIDTH]);
    return IDX_WIDTH'(addr ^ color_rs);
  endfunction

  mm_state_e            state_q, state_d;
  logic                 rdy_q, rdy_d;
  logic [WR_W-1:0]      tok_q;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [IDX_WIDTH:0]   occ_q, occ_d;
  logic                 err_q, err_d;
  logic                 prv_q, prv_d;
  logic [PR_W-1:0]      prd_q, prd_d;

  logic                 in_xfer;
  logic                 tbl_we;
  logic [IDX_WIDTH-1:0] tok_idx;
  logic                 tok_side;
  logic                 tok_opt_ok;
  logic [ENTRY_W-1:0]   ent;
  logic                 ent_side;
  logic [TAG_W-1:0]     ent_tag;
  logic [DATA_WIDTH-1:0] ent_data;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;

  // Ready is only ever high in S_READ, so this is the accept strobe.
  assign in_xfer    = bus.RECEIVE_WR_VALID & rdy_q;

  assign tok_idx    = wr_index(tok_q);
  assign tok_side   = (wr_opt(tok_q) == DEST_OPTION_RIGHT);
  assign tok_opt_ok = (wr_opt(tok_q) == DEST_OPTION_LEFT) ||
                      (wr_opt(tok_q) == DEST_OPTION_RIGHT);

  assign ent_side   = ent[ENTRY_W-1];
  assign ent_tag    = ent[DATA_WIDTH +: TAG_W];
  assign ent_data   = ent[DATA_WIDTH-1:0];

  // Operands leave in LEFT/RIGHT order whichever side arrived first.
  assign left_data  = tok_side ? ent_data : wr_data(tok_q);
  assign right_data = tok_side ? wr_data(tok_q) : ent_data;

  match_table #(
    .IDX_WIDTH   (IDX_WIDTH),
    .ENTRY_WIDTH (ENTRY_W)
  ) u_match_table (
    .CLK       (CLK),
    .wr_en_i   (tbl_we),
    .wr_addr_i (tok_idx),
    .wr_data_i ({tok_side, wr_tag(tok_q), wr_data(tok_q)}),
    .rd_en_i   (in_xfer),
    .rd_addr_i (wr_index(bus.RECEIVE_WR_DATA)),
    .rd_data_o (ent)
  );

  // Next-state, table update and output-packet decisions.
  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    occ_d   = occ_q;
    err_d   = err_q;
    prv_d   = prv_q;
    prd_d   = prd_q;
    tbl_we  = 1'b0;
    unique case (state_q)
      S_READ: begin
        rdy_d = 1'b1;
        if (in_xfer) begin
          rdy_d   = 1'b0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_READ;
        rdy_d   = 1'b1;
        if (!tok_opt_ok) begin
          err_d = 1'b1;
        end else if (!vld_q[tok_idx]) begin
          tbl_we         = 1'b1;
          vld_d[tok_idx] = 1'b1;
          occ_d          = occ_q + 1'b1;
        end else if ((ent_tag == wr_tag(tok_q)) && (ent_side != tok_side)) begin
          vld_d[tok_idx] = 1'b0;
          occ_d          = occ_q - 1'b1;
          prd_d          = {DEST_OPTION_EXEC, wr_tag(tok_q), left_data, right_data};
          state_d        = S_PR_WRITE;
          rdy_d          = 1'b0;
        end else begin
          // Slot collision or a second operand for the same side.
          err_d = 1'b1;
        end
      end
      S_PR_WRITE: begin
        if (!prv_q) begin
          prv_d = 1'b1;
        end else if (bus.SEND_PR_READY) begin
          prv_d   = 1'b0;
          state_d = S_READ;
          rdy_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_READ;
      end
    endcase
  end

  // Control and output registers; reset drops any held token or pending packet.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_READ;
      rdy_q   <= 1'b0;
      vld_q   <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
      prv_q   <= 1'b0;
      prd_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
      prv_q   <= prv_d;
      prd_q   <= prd_d;
    end
  end

  // Holding register for the accepted token.
  always_ff @(posedge CLK) begin
    if (in_xfer) tok_q <= bus.RECEIVE_WR_DATA;
  end

  assign bus.RECEIVE_WR_READY = rdy_q;
  assign bus.SEND_PR_VALID    = prv_q;
  assign bus.SEND_PR_DATA     = prd_q;
  assign MATCH_ERROR          = err_q;
  assign OCCUPANCY            = occ_q;

endmodule

// File: tb/tb_matching_memory.sv
// Directed bench for matching_memory with a tag-table reference model and a
// per-cycle output checker.
module tb_matching_memory;
  import matching_memory_pkg::*;

  localparam int A    = 16;
  localparam int C    = 16;
  localparam int D    = 32;
  localparam int I    = 6;
  localparam int N    = 1 << I;
  localparam int PR_W = 3 + A + C + 2 * D;

  logic         CLK = 1'b0;
  logic         RST;
  logic         MATCH_ERROR;
  logic [I:0]   OCCUPANCY;

  always #5 CLK = ~CLK;

  matching_memory_if #(.ADDR_WIDTH(A), .COLOR_WIDTH(C), .DATA_WIDTH(D)) bus ();

  matching_memory #(
    .ADDR_WIDTH (A),
    .COLOR_WIDTH(C),
    .DATA_WIDTH (D),
    .IDX_WIDTH  (I)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .MATCH_ERROR(MATCH_ERROR),
    .OCCUPANCY  (OCCUPANCY)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=event", name);
  endtask

  // ---------------- reference model ----------------
  bit              m_vld   [N];
  bit              m_right [N];
  logic [A-1:0]    m_addr  [N];
  logic [C-1:0]    m_color [N];
  logic [D-1:0]    m_data  [N];
  int              m_occ;
  bit              m_err;
  logic [PR_W-1:0] exp_q [$];
  int              pkt_count = 0;
  logic [PR_W-1:0] last_pkt  = '0;

  function automatic void model_reset();
    for (int k = 0; k < N; k++) m_vld[k] = 1'b0;
    m_occ = 0;
    m_err = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_token(input logic [2:0] opt, input logic [A-1:0] a,
                                      input logic [C-1:0] c, input logic [D-1:0] d);
    int  slot;
    bit  is_right;
    if (opt != DEST_OPTION_LEFT && opt != DEST_OPTION_RIGHT) begin
      m_err = 1'b1;
      return;
    end
    is_right = (opt == DEST_OPTION_RIGHT);
    slot = int'(a ^ c) % N;
    if (!m_vld[slot]) begin
      m_vld[slot]   = 1'b1;
      m_right[slot] = is_right;
      m_addr[slot]  = a;
      m_color[slot] = c;
      m_data[slot]  = d;
      m_occ++;
    end else if (m_addr[slot] == a && m_color[slot] == c && m_right[slot] != is_right) begin
      m_vld[slot] = 1'b0;
      m_occ--;
      if (is_right) exp_q.push_back({DEST_OPTION_EXEC, a, c, m_data[slot], d});
      else          exp_q.push_back({DEST_OPTION_EXEC, a, c, d, m_data[slot]});
    end else begin
      m_err = 1'b1;
    end
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    bit              hold_prev;
    logic [PR_W-1:0] hold_data;
    logic [PR_W-1:0] want;
    hold_prev = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        model_reset();
        hold_prev = 1'b0;
      end else begin
        if (bus.RECEIVE_WR_READY) begin
          check("occupancy", OCCUPANCY, m_occ);
          check("match_error", MATCH_ERROR, m_err);
        end
        if (hold_prev) begin
          check("pr_hold_valid", bus.SEND_PR_VALID, 1);
          check("pr_hold_data", bus.SEND_PR_DATA, hold_data);
        end
        if (bus.SEND_PR_VALID) check("wr_ready_during_pr", bus.RECEIVE_WR_READY, 0);
        if (bus.SEND_PR_VALID && bus.SEND_PR_READY) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pr_unexpected got=%0h want=none", bus.SEND_PR_DATA);
          end else begin
            want = exp_q.pop_front();
            check("pr_packet", bus.SEND_PR_DATA, want);
          end
          pkt_count++;
          last_pkt = bus.SEND_PR_DATA;
        end
        hold_prev = bus.SEND_PR_VALID && !bus.SEND_PR_READY;
        hold_data = bus.SEND_PR_DATA;
        if (bus.RECEIVE_WR_VALID && bus.RECEIVE_WR_READY)
          model_token(bus.RECEIVE_WR_DATA[A+C+D +: 3], bus.RECEIVE_WR_DATA[C+D +: A],
                      bus.RECEIVE_WR_DATA[D +: C], bus.RECEIVE_WR_DATA[D-1:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [2:0] opt, input logic [A-1:0] a,
                      input logic [C-1:0] c, input logic [D-1:0] d);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    bus.RECEIVE_WR_VALID = 1'b1;
    bus.RECEIVE_WR_DATA  = {opt, a, c, d};
    while (!done) begin
      @(negedge CLK);
      if (bus.RECEIVE_WR_READY) done = 1'b1;
      else if (++n > 200) begin
        timeout_fail("send_accept");
        done = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    bus.RECEIVE_WR_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.RECEIVE_WR_READY && n < 200);
    if (!bus.RECEIVE_WR_READY) timeout_fail("wait_idle");
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_prv();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.SEND_PR_VALID && n < 200);
    if (!bus.SEND_PR_VALID) timeout_fail("wait_pr_valid");
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.RECEIVE_WR_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int              p;
    logic [PR_W-1:0] held;
    RST = 1'b1;
    bus.RECEIVE_WR_VALID = 1'b0;
    bus.RECEIVE_WR_DATA  = '0;
    bus.SEND_PR_READY    = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wr_ready", bus.RECEIVE_WR_READY, 0);
    check("rst_pr_valid", bus.SEND_PR_VALID, 0);
    check("rst_pr_data", bus.SEND_PR_DATA, 0);
    check("rst_error", MATCH_ERROR, 0);
    check("rst_occ", OCCUPANCY, 0);
    RST = 1'b0;
    @(negedge CLK);
    check("wr_ready_first_cycle", bus.RECEIVE_WR_READY, 0);
    @(posedge CLK);
    #1;
    check("wr_ready_after_release", bus.RECEIVE_WR_READY, 1);

    // Basic LEFT then RIGHT pair.
    send(DEST_OPTION_LEFT, 16'h0010, 16'h0001, 32'hAAAA_0001);
    wait_idle();
    check("pair_occ_after_left", OCCUPANCY, 1);
    p = pkt_count;
    send(DEST_OPTION_RIGHT, 16'h0010, 16'h0001, 32'hBBBB_0002);
    wait_idle();
    check("pair_occ_after_right", OCCUPANCY, 0);
    check("pair_pkt_count", pkt_count, p + 1);
    check("pair_pkt_literal", last_pkt,
          {3'd0, 16'h0010, 16'h0001, 32'hAAAA_0001, 32'hBBBB_0002});

    // RIGHT first: operands still come out LEFT, RIGHT.
    send(DEST_OPTION_RIGHT, 16'h0040, 16'h0002, 32'd5);
    send(DEST_OPTION_LEFT, 16'h0040, 16'h0002, 32'd7);
    wait_idle();
    check("order_data1_data2", last_pkt[63:0], {32'd7, 32'd5});

    // Unsupported option: error, table untouched.
    send(3'd5, 16'h0077, 16'h0000, 32'h1234);
    wait_idle();
    check("badopt_error", MATCH_ERROR, 1);
    check("badopt_occ", OCCUPANCY, 0);
    do_reset();
    check("error_cleared_by_rst", MATCH_ERROR, 0);

    // Two different tags on slot 3.
    p = pkt_count;
    send(DEST_OPTION_LEFT, 16'h0003, 16'h0000, 32'h1);
    send(DEST_OPTION_LEFT, 16'h0002, 16'h0001, 32'h2);
    wait_idle();
    check("collision_error", MATCH_ERROR, 1);
    check("collision_occ", OCCUPANCY, 1);
    check("collision_no_pkt", pkt_count, p);

    // Output back-pressure for 10 cycles.
    do_reset();
    bus.SEND_PR_READY = 1'b0;
    send(DEST_OPTION_LEFT, 16'h0100, 16'h0005, 32'h11);
    send(DEST_OPTION_RIGHT, 16'h0100, 16'h0005, 32'h22);
    wait_prv();
    held = {3'd0, 16'h0100, 16'h0005, 32'h11, 32'h22};
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("stall_valid", bus.SEND_PR_VALID, 1);
      check("stall_data", bus.SEND_PR_DATA, held);
      check("stall_wr_ready", bus.RECEIVE_WR_READY, 0);
    end
    p = pkt_count;
    @(posedge CLK);
    #1;
    bus.SEND_PR_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("stall_valid_falls", bus.SEND_PR_VALID, 0);
    wait_idle();
    check("stall_single_xfer", pkt_count, p + 1);

    // Fill every slot, overflow attempt, then drain.
    do_reset();
    for (int k = 0; k < N; k++) send(DEST_OPTION_LEFT, 16'(k), 16'h0000, 32'h1000 + k);
    wait_idle();
    check("full_occ", OCCUPANCY, N);
    send(DEST_OPTION_LEFT, 16'h0040, 16'h0000, 32'hDEAD);
    wait_idle();
    check("full_extra_error", MATCH_ERROR, 1);
    check("full_extra_occ", OCCUPANCY, N);
    p = pkt_count;
    for (int k = 0; k < N; k++) send(DEST_OPTION_RIGHT, 16'(k), 16'h0000, 32'h2000 + k);
    wait_idle();
    check("drain_occ", OCCUPANCY, 0);
    check("drain_pkts", pkt_count, p + N);
    check("drain_last_pkt", last_pkt, {3'd0, 16'h003F, 16'h0000, 32'h103F, 32'h203F});

    // Reset while a packet is pending.
    do_reset();
    send(DEST_OPTION_LEFT, 16'h0020, 16'h0007, 32'h1);
    bus.SEND_PR_READY = 1'b0;
    send(DEST_OPTION_RIGHT, 16'h0020, 16'h0007, 32'h2);
    wait_prv();
    do_reset();
    check("midrst_pr_valid", bus.SEND_PR_VALID, 0);
    check("midrst_occ", OCCUPANCY, 0);
    check("midrst_pr_data", bus.SEND_PR_DATA, 0);
    bus.SEND_PR_READY = 1'b1;
    p = pkt_count;
    send(DEST_OPTION_RIGHT, 16'h0020, 16'h0007, 32'h3);
    wait_idle();
    check("midrst_right_stored", OCCUPANCY, 1);
    check("midrst_no_pkt", pkt_count, p);

    repeat (3) @(posedge CLK);
    check("expected_pkts_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matching_memory.md
MATCHING_MEMORY -- requirements
Module: matching_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, instruction destination address width.
REQ-002 SHALL have parameter COLOR_WIDTH, default 16, token color width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, operand width.
REQ-004 SHALL have parameter IDX_WIDTH, default 6, table index width (2^IDX_WIDTH entries).
REQ-005 SHALL have port CLK  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  synchronous reset, active-high.
REQ-007 SHALL have port RECEIVE_WR_VALID  input  1  worker-result valid from dispatcher.
REQ-008 SHALL have port RECEIVE_WR_DATA  input  WORKER_RESULT_WIDTH  worker result, MSB-first {dest_option[2:0], dest_addr, color, data}.
REQ-009 SHALL have port RECEIVE_WR_READY  output  1  registered ready.
REQ-010 SHALL have port SEND_PR_VALID  output  1  registered packet-request valid to packet_loader.
REQ-011 SHALL have port SEND_PR_DATA  output  PACKET_REQUEST_WIDTH  {dest_option, dest_addr, color, data1, data2}.
REQ-012 SHALL have port SEND_PR_READY  input  1  packet_loader ready.
REQ-013 SHALL have port MATCH_ERROR  output  1  sticky error flag.
REQ-014 SHALL have port OCCUPANCY  output  IDX_WIDTH+1  count of valid entries.

Function
REQ-015 Transfer occurs on any channel only when VALID and READY are both high on a rising edge.
REQ-016 FSM states: S_READ, S_LOOKUP, S_PR_WRITE; one token in flight at a time.
REQ-017 S_READ: RECEIVE_WR_READY driven 1; drops to 0 the cycle after a transfer; input captured into a holding register on transfer; next state S_LOOKUP.
REQ-018 Table index = (dest_addr XOR color) [IDX_WIDTH-1:0]; color zero-extended/truncated to ADDR_WIDTH before XOR.
REQ-019 Entry = {valid, side, dest_addr, color, data}; valid bits in flops, remainder in synchronous-read array read during S_LOOKUP.
REQ-020 S_LOOKUP, entry invalid, option LEFT/RIGHT: write entry with side, set valid, OCCUPANCY+1, next S_READ.
REQ-021 S_LOOKUP, entry valid, tag (addr,color) equal, opposite side: clear valid, OCCUPANCY-1, load output register, next S_PR_WRITE.
REQ-022 Output packet: dest_option=DEST_OPTION_EXEC, dest_addr and color of token, data1=LEFT operand, data2=RIGHT operand, regardless of arrival order.
REQ-023 S_LOOKUP, entry valid with tag mismatch (collision) or same side (duplicate): set MATCH_ERROR, drop token, entry unchanged, next S_READ.
REQ-024 Option other than LEFT/RIGHT: set MATCH_ERROR, drop, table unchanged, next S_READ.
REQ-025 S_PR_WRITE: SEND_PR_VALID rises one cycle after entry, held with SEND_PR_DATA stable until transfer, falls next cycle; next S_READ.
REQ-026 Latency: input transfer at edge t -> SEND_PR_VALID high after edge t+2 for a matching token.
REQ-027 OCCUPANCY never exceeds 2^IDX_WIDTH; a full table only produces matches or MATCH_ERROR, never a stall.
REQ-028 MATCH_ERROR cleared only by RST.
REQ-029 Encodings of DEST_OPTION_* taken from the shared parameter package.

Reset
REQ-030 RST: state S_READ, all valid bits 0, OCCUPANCY 0, RECEIVE_WR_READY 0, SEND_PR_VALID 0, MATCH_ERROR 0, SEND_PR_DATA 0.
REQ-031 RST mid-operation discards held token and pending packet; array data contents need not clear.
REQ-032 First cycle after RST release: RECEIVE_WR_READY rises at next edge.

Structure
REQ-033 Field widths, WORKER_RESULT_WIDTH, PACKET_REQUEST_WIDTH, DEST_OPTION_* encodings, field extract/construct functions belong in the shared parameter/include package.
REQ-034 Operand storage SHALL be a sub-module match_table (synchronous-read, single-write dual-port array); FSM and valid flops stay in matching_memory.

Verification
REQ-035 LEFT addr=0x0010 color=0x0001 data=0xAAAA_0001, then RIGHT same tag data=0xBBBB_0002 -> one packet {EXEC,0x0010,0x0001,0xAAAA0001,0xBBBB0002}, OCCUPANCY 1 then 0.
REQ-036 RIGHT first data=5 then LEFT data=7, same tag -> data1=7, data2=5.
REQ-037 LEFT addr=0x0003 color=0, then LEFT addr=0x0002 color=0x0001 (same index 3) -> MATCH_ERROR=1, no packet, OCCUPANCY 1.
REQ-038 Matching pair with SEND_PR_READY held 0 for 10 cycles -> SEND_PR_VALID and data stable 10 cycles, RECEIVE_WR_READY 0 throughout, single transfer on release.
REQ-039 64 distinct-index LEFT tokens -> OCCUPANCY 64; 64 matching RIGHT tokens -> 64 packets, OCCUPANCY 0.
REQ-040 RST asserted while in S_PR_WRITE -> SEND_PR_VALID 0, OCCUPANCY 0, later RIGHT for stored tag stored (no packet).
